// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and default parameters for the matrix-multiply sequencer
package matmul_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam int N_DEF = 8;
  localparam int AW_DEF = 6;
  localparam int RD_LAT_DEF = 1;
  localparam int CW = 11;
  localparam int TOTAL_ISSUE = N_DEF * N_DEF * N_DEF;
  localparam int RUN_CYCLES = TOTAL_ISSUE + RD_LAT_DEF + 1;
  function automatic int run_cycles(input int n, input int rd_lat);
    return n * n * n + rd_lat + 1;
  endfunction
endpackage

// File: rtl/matmul_sequencer_pipe.sv
// seq_delay_pipe: aligns issue-time tags with RAM read latency and emits MAC/C-write strobes
module seq_delay_pipe #(
  parameter int AW = 6,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid,
  input  logic          clr,
  input  logic          last,
  input  logic [AW-1:0] e,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          wr_c,
  output logic [AW-1:0] addr_c
);
  logic [RD_LAT-1:0] v_q, c_q, l_q;
  logic [AW-1:0] e_q [RD_LAT];
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      c_q <= '0;
      l_q <= '0;
      for (int s = 0; s < RD_LAT; s++) e_q[s] <= '0;
      wr_c <= 1'b0;
      addr_c <= '0;
    end else begin
      v_q[0] <= valid;
      c_q[0] <= clr;
      l_q[0] <= last;
      e_q[0] <= e;
      for (int s = 1; s < RD_LAT; s++) begin
        v_q[s] <= v_q[s-1];
        c_q[s] <= c_q[s-1];
        l_q[s] <= l_q[s-1];
        e_q[s] <= e_q[s-1];
      end
      // write one cycle after the last accumulate so the sum is complete
      wr_c <= l_q[RD_LAT-1];
      addr_c <= l_q[RD_LAT-1] ? e_q[RD_LAT-1] : '0;
    end
  end
  assign mac_en = v_q[RD_LAT-1];
  assign mac_clr = c_q[RD_LAT-1];
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: address/strobe sequencer for an N x N matrix multiply C = A*B
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int AW = AW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          wr_c,
  output logic [AW-1:0] addr_c,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_count
);
  localparam int LN = $clog2(N);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(run_cycles(N, RD_LAT) - 1);
  state_t state, state_n;
  logic [LN-1:0] i, j, k, i_n, j_n, k_n;
  logic [AW-1:0] addr_a_n, addr_b_n;
  logic [CW-1:0] count_n;
  logic running;
  assign running = state == ISSUE || state == DRAIN;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      {i, j, k} <= '0;
      addr_a <= '0;
      addr_b <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cycle_count <= '0;
    end else begin
      state <= state_n;
      {i, j, k} <= {i_n, j_n, k_n};
      addr_a <= addr_a_n;
      addr_b <= addr_b_n;
      busy <= state_n == ISSUE || state_n == DRAIN;
      done <= state_n == DONE;
      cycle_count <= count_n;
    end
  end
  always_comb begin
    state_n = state == ISSUE ? (&{i, j, k} ? DRAIN : ISSUE) :
              state == DRAIN ? (cycle_count == LAST_CYCLE ? DONE : DRAIN) :
              start ? ISSUE : state;
  end
  // {i,j,k} is one counter: k innermost, carries ripple into j then i
  always_comb begin
    {i_n, j_n, k_n} = (state == ISSUE && state_n == ISSUE) ? {i, j, k} + 1'b1 : '0;
    addr_a_n = state_n == ISSUE ? {i_n, k_n} : '0;
    addr_b_n = state_n == ISSUE ? {k_n, j_n} : '0;
    count_n = running ? cycle_count + 1'b1 : (state_n == ISSUE ? '0 : cycle_count);
  end
  seq_delay_pipe #(.AW(AW), .RD_LAT(RD_LAT)) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .valid  (state == ISSUE),
    .clr    (state == ISSUE && k == '0),
    .last   (state == ISSUE && &k),
    .e      ({i, j}),
    .mac_en (mac_en),
    .mac_clr(mac_clr),
    .wr_c   (wr_c),
    .addr_c (addr_c)
  );
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: three parameterisations driven by shared random stimulus, scoreboarded C writes
module tb_matmul_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] done_v;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  task automatic chk(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL d%0d %s: got %0d expected %0d at %0t", g, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int N = g == 2 ? 2 : 8;
    localparam int AW = g == 2 ? 2 : 6;
    localparam int L = g == 1 ? 2 : 1;
    localparam int T = N * N * N;
    localparam int RUN = T + L + 1;
    logic [AW-1:0] addr_a, addr_b, addr_c;
    logic mac_en, mac_clr, wr_c, busy;
    logic [10:0] cycle_count;
    int c = -1;
    bit mdone = 1'b0;
    int wq_cyc[$];
    int wq_addr[$];

    matmul_sequencer #(.N(N), .AW(AW), .RD_LAT(L)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .addr_a     (addr_a),
      .addr_b     (addr_b),
      .mac_en     (mac_en),
      .mac_clr    (mac_clr),
      .wr_c       (wr_c),
      .addr_c     (addr_c),
      .busy       (busy),
      .done       (done_v[g]),
      .cycle_count(cycle_count)
    );

    // reference model: c is the cycle index within a run, -1 when not running
    initial forever begin
      @(posedge clk);
      if (reset) begin
        c = -1;
        mdone = 1'b0;
        wq_cyc.delete();
        wq_addr.delete();
      end else if (c >= 0) begin
        c++;
        if (c == RUN) begin
          c = -1;
          mdone = 1'b1;
        end
      end else if (start) begin
        c = 0;
        mdone = 1'b0;
        for (int e = 0; e < N * N; e++) begin
          wq_cyc.push_back((e + 1) * N + L);
          wq_addr.push_back(e);
        end
      end
    end

    initial begin
      int t;
      forever begin
        @(negedge clk);
        t = c - L;
        if (c >= 0) begin
          chk(g, "busy", busy, 1);
          chk(g, "done", done_v[g], 0);
          chk(g, "cycle_count", cycle_count, c);
          chk(g, "addr_a", addr_a, c < T ? (c / (N * N)) * N + c % N : 0);
          chk(g, "addr_b", addr_b, c < T ? (c % N) * N + (c / N) % N : 0);
          chk(g, "mac_en", mac_en, t >= 0 && t < T);
          chk(g, "mac_clr", mac_clr, t >= 0 && t < T && t % N == 0);
        end else begin
          chk(g, "busy idle", busy, 0);
          chk(g, "done idle", done_v[g], mdone);
          chk(g, "cycle_count idle", cycle_count, mdone ? RUN : 0);
          chk(g, "addr_a idle", addr_a, 0);
          chk(g, "addr_b idle", addr_b, 0);
          chk(g, "mac_en idle", mac_en, 0);
          chk(g, "mac_clr idle", mac_clr, 0);
        end
        if (wr_c) begin
          if (wq_cyc.size() == 0) chk(g, "wr_c unexpected", 1, 0);
          else begin
            chk(g, "wr_c cycle", c, wq_cyc.pop_front());
            chk(g, "addr_c", addr_c, wq_addr.pop_front());
          end
        end else begin
          chk(g, "addr_c idle", addr_c, 0);
          if (wq_cyc.size() > 0 && wq_cyc[0] == c) begin
            chk(g, "wr_c missing", 0, 1);
            void'(wq_cyc.pop_front());
            void'(wq_addr.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_done(input int g);
    int n = 0;
    while (done_v[g] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(g, "done timeout", done_v[g] === 1'b1, 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (400) begin
      start = $urandom_range(0, 7) == 0;
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_done(0);
    @(negedge clk);
    start = 1'b0;
    wait_done(0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0);
    repeat (5) @(negedge clk);
    chk(0, "pending writes", u[0].wq_cyc.size(), 0);
    chk(1, "pending writes", u[1].wq_cyc.size(), 0);
    chk(2, "pending writes", u[2].wq_cyc.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
